// File: rtl/bfly_dif_pipe_if.sv
// Valid/ready bundle for the DIF butterfly: operand pair and twiddle in, result pair out.
interface bfly_dif_pipe_if #(
   parameter int W = 16
);
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_a_re;
   logic [W-1:0] i_a_im;
   logic [W-1:0] i_b_re;
   logic [W-1:0] i_b_im;
   logic [W-1:0] i_w_re;
   logic [W-1:0] i_w_im;
   logic         i_inv;
   logic         i_last;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_y0_re;
   logic [W-1:0] o_y0_im;
   logic [W-1:0] o_y1_re;
   logic [W-1:0] o_y1_im;
   logic         o_last;

   // Butterfly side
   modport slave (
      input  i_valid, i_a_re, i_a_im, i_b_re, i_b_im, i_w_re, i_w_im, i_inv, i_last, i_ready,
      output o_ready, o_valid, o_y0_re, o_y0_im, o_y1_re, o_y1_im, o_last
   );

   // Producer / consumer side
   modport master (
      output i_valid, i_a_re, i_a_im, i_b_re, i_b_im, i_w_re, i_w_im, i_inv, i_last, i_ready,
      input  o_ready, o_valid, o_y0_re, o_y0_im, o_y1_re, o_y1_im, o_last
   );
endinterface

// File: rtl/bfly_dif_pipe.sv
// Two-stage radix-2 DIF (Gentleman-Sande) butterfly: y0 = A+B, y1 = (A-B)*W.
// S1 forms sum/difference (optionally halved) and the possibly conjugated twiddle;
// S2 does the complex multiply with round-half-up and saturation.
module bfly_dif_pipe #(
   parameter int W        = 16,
   parameter int FRAC     = 14,
   parameter bit SCALE_EN = 1'b1
) (
   input logic          i_clk,
   input logic          i_rst_n,
   bfly_dif_pipe_if.slave bus
);

   localparam logic [W-1:0]       SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]       SMIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W:0] HALF = {{(2*W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

   function automatic logic [W-1:0] scale_f(input logic [W:0] v);
      if (SCALE_EN) scale_f = v[W:1];
      else          scale_f = v[W-1:0];
   endfunction

   function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
      if (v == SMIN) neg_sat = SMAX;
      else           neg_sat = -v;
   endfunction

   function automatic logic [W-1:0] rnd_sat(input logic signed [2*W:0] x);
      logic signed [2*W:0] r;
      r = (x + HALF) >>> FRAC;
      if (r[2*W:W-1] == '0 || r[2*W:W-1] == '1) rnd_sat = r[W-1:0];
      else if (r[2*W])                           rnd_sat = SMIN;
      else                                       rnd_sat = SMAX;
   endfunction

   logic en;

   logic         s1_valid_d, s1_valid_q;
   logic         s1_last_d,  s1_last_q;
   logic [W-1:0] s1_sr_d, s1_sr_q, s1_si_d, s1_si_q;
   logic [W-1:0] s1_dr_d, s1_dr_q, s1_di_d, s1_di_q;
   logic [W-1:0] s1_wr_d, s1_wr_q, s1_wi_d, s1_wi_q;

   logic         s2_valid_d, s2_valid_q;
   logic         s2_last_d,  s2_last_q;
   logic [W-1:0] y0_re_d, y0_re_q, y0_im_d, y0_im_q;
   logic [W-1:0] y1_re_d, y1_re_q, y1_im_d, y1_im_q;

   logic [W:0]          sum_re, sum_im, dif_re, dif_im;
   logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic [2*W:0]        y1_re_full, y1_im_full;

   assign en          = ~s2_valid_q | bus.i_ready;
   assign bus.o_ready = en;

   // S1 next state: full-width sum/difference, scaled or wrapped, plus twiddle conjugation
   always_comb begin
      sum_re = {bus.i_a_re[W-1], bus.i_a_re} + {bus.i_b_re[W-1], bus.i_b_re};
      sum_im = {bus.i_a_im[W-1], bus.i_a_im} + {bus.i_b_im[W-1], bus.i_b_im};
      dif_re = {bus.i_a_re[W-1], bus.i_a_re} - {bus.i_b_re[W-1], bus.i_b_re};
      dif_im = {bus.i_a_im[W-1], bus.i_a_im} - {bus.i_b_im[W-1], bus.i_b_im};
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      s1_sr_d    = s1_sr_q;
      s1_si_d    = s1_si_q;
      s1_dr_d    = s1_dr_q;
      s1_di_d    = s1_di_q;
      s1_wr_d    = s1_wr_q;
      s1_wi_d    = s1_wi_q;
      if (en) begin
         s1_valid_d = bus.i_valid;
         s1_last_d  = bus.i_last;
         s1_sr_d    = scale_f(sum_re);
         s1_si_d    = scale_f(sum_im);
         s1_dr_d    = scale_f(dif_re);
         s1_di_d    = scale_f(dif_im);
         s1_wr_d    = bus.i_w_re;
         s1_wi_d    = bus.i_inv ? neg_sat(bus.i_w_im) : bus.i_w_im;
      end
   end

   // S2 next state: complex multiply of difference by twiddle, round and saturate
   always_comb begin
      p_rr = (2*W)'($signed(s1_dr_q)) * (2*W)'($signed(s1_wr_q));
      p_ii = (2*W)'($signed(s1_di_q)) * (2*W)'($signed(s1_wi_q));
      p_ri = (2*W)'($signed(s1_dr_q)) * (2*W)'($signed(s1_wi_q));
      p_ir = (2*W)'($signed(s1_di_q)) * (2*W)'($signed(s1_wr_q));
      y1_re_full = {p_rr[2*W-1], p_rr} - {p_ii[2*W-1], p_ii};
      y1_im_full = {p_ri[2*W-1], p_ri} + {p_ir[2*W-1], p_ir};
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
      y0_re_d    = y0_re_q;
      y0_im_d    = y0_im_q;
      y1_re_d    = y1_re_q;
      y1_im_d    = y1_im_q;
      if (en) begin
         s2_valid_d = s1_valid_q;
         s2_last_d  = s1_last_q;
         y0_re_d    = s1_sr_q;
         y0_im_d    = s1_si_q;
         y1_re_d    = rnd_sat(y1_re_full);
         y1_im_d    = rnd_sat(y1_im_full);
      end
   end

   // Pipeline registers; reset clears valid, sideband and data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sr_q    <= '0;
         s1_si_q    <= '0;
         s1_dr_q    <= '0;
         s1_di_q    <= '0;
         s1_wr_q    <= '0;
         s1_wi_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         y0_re_q    <= '0;
         y0_im_q    <= '0;
         y1_re_q    <= '0;
         y1_im_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s1_sr_q    <= s1_sr_d;
         s1_si_q    <= s1_si_d;
         s1_dr_q    <= s1_dr_d;
         s1_di_q    <= s1_di_d;
         s1_wr_q    <= s1_wr_d;
         s1_wi_q    <= s1_wi_d;
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
         y0_re_q    <= y0_re_d;
         y0_im_q    <= y0_im_d;
         y1_re_q    <= y1_re_d;
         y1_im_q    <= y1_im_d;
      end
   end

   assign bus.o_valid = s2_valid_q;
   assign bus.o_last  = s2_last_q;
   assign bus.o_y0_re = y0_re_q;
   assign bus.o_y0_im = y0_im_q;
   assign bus.o_y1_re = y1_re_q;
   assign bus.o_y1_im = y1_im_q;

endmodule

// File: tb/tb_bfly_dif_pipe.sv
// Bench for bfly_dif_pipe: one unscaled and one scaled instance share the same stimulus;
// an arithmetic model plus queue checks every output transfer, directed literals pin the model.
module tb_bfly_dif_pipe;
   localparam int W    = 16;
   localparam int FRAC = 14;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         valid, rdy, inv, last;
   logic [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;

   bfly_dif_pipe_if #(.W(W)) bus0 ();
   bfly_dif_pipe_if #(.W(W)) bus1 ();

   assign bus0.i_valid = valid;  assign bus1.i_valid = valid;
   assign bus0.i_ready = rdy;    assign bus1.i_ready = rdy;
   assign bus0.i_inv   = inv;    assign bus1.i_inv   = inv;
   assign bus0.i_last  = last;   assign bus1.i_last  = last;
   assign bus0.i_a_re  = a_re;   assign bus1.i_a_re  = a_re;
   assign bus0.i_a_im  = a_im;   assign bus1.i_a_im  = a_im;
   assign bus0.i_b_re  = b_re;   assign bus1.i_b_re  = b_re;
   assign bus0.i_b_im  = b_im;   assign bus1.i_b_im  = b_im;
   assign bus0.i_w_re  = w_re;   assign bus1.i_w_re  = w_re;
   assign bus0.i_w_im  = w_im;   assign bus1.i_w_im  = w_im;

   bfly_dif_pipe #(.W(W), .FRAC(FRAC), .SCALE_EN(1'b0)) u_dut_s0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
   bfly_dif_pipe #(.W(W), .FRAC(FRAC), .SCALE_EN(1'b1)) u_dut_s1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

   // act[k] = {y1_im, y1_re, y0_im, y0_re} of the instance with SCALE_EN = k
   logic [1:0][3:0][15:0] act;
   logic [1:0]            vo, ro, lo;
   assign act[0] = {bus0.o_y1_im, bus0.o_y1_re, bus0.o_y0_im, bus0.o_y0_re};
   assign act[1] = {bus1.o_y1_im, bus1.o_y1_re, bus1.o_y0_im, bus1.o_y0_re};
   assign vo = {bus1.o_valid, bus0.o_valid};
   assign ro = {bus1.o_ready, bus0.o_ready};
   assign lo = {bus1.o_last,  bus0.o_last};

   typedef struct packed {
      logic [1:0][3:0][15:0] y;
      logic                  last;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   out_cnt = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic int wrap16(input int v);
      return ((v % 65536) + 65536 + 32768) % 65536 - 32768;
   endfunction

   function automatic longint clamp16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference butterfly in plain integer arithmetic
   function automatic logic [3:0][15:0] model(input int ar, ai, br, bi, wr, wi,
                                              input bit cj, input bit scale);
      int     sr, si, dr, di, wq;
      longint pr, pq;
      sr = ar + br;  si = ai + bi;  dr = ar - br;  di = ai - bi;
      if (scale) begin
         sr = sr >>> 1;  si = si >>> 1;  dr = dr >>> 1;  di = di >>> 1;
      end else begin
         sr = wrap16(sr);  si = wrap16(si);  dr = wrap16(dr);  di = wrap16(di);
      end
      wq = cj ? -wi : wi;
      if (wq > 32767) wq = 32767;
      pr = longint'(dr) * wr - longint'(di) * wq;
      pq = longint'(dr) * wq + longint'(di) * wr;
      pr = clamp16((pr + 8192) >>> 14);
      pq = clamp16((pq + 8192) >>> 14);
      return {16'(pq), 16'(pr), 16'(si), 16'(sr)};
   endfunction

   logic                  prev_stall = 1'b0;
   logic [1:0][3:0][15:0] prev_act;

   // Scoreboard: push on input transfer, pop and compare on output transfer, check stall hold
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) chk("o_ready_rule", ro[k], !vo[k] || rdy);
         if (prev_stall) begin
            for (int k = 0; k < 2; k++) begin
               chk("stall_hold_valid", vo[k], 1'b1);
               chk("stall_hold_data", act[k], prev_act[k]);
            end
         end
         if (valid && ro[1]) begin
            for (int k = 0; k < 2; k++)
               e.y[k] = model(int'($signed(a_re)), int'($signed(a_im)), int'($signed(b_re)),
                              int'($signed(b_im)), int'($signed(w_re)), int'($signed(w_im)),
                              inv, k != 0);
            e.last = last;
            exp_q.push_back(e);
         end
         if (vo[1] && rdy) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got output with no pending sample, required none");
            end else begin
               e = exp_q.pop_front();
               out_cnt++;
               for (int k = 0; k < 2; k++) begin
                  chk("model_y", act[k], e.y[k]);
                  chk("model_last", lo[k], e.last);
               end
            end
         end
         prev_stall = vo[1] && !rdy;
         prev_act   = act;
      end
   end

   task automatic set_in(input int ar, ai, br, bi, wr, wi, input logic cj, input logic lst);
      a_re = 16'(ar);  a_im = 16'(ai);
      b_re = 16'(br);  b_im = 16'(bi);
      w_re = 16'(wr);  w_im = 16'(wi);
      inv  = cj;       last = lst;
   endtask

   // One isolated sample with literal expectations and a 2-cycle latency check
   task automatic send_lit(input int k, input int ar, ai, br, bi, wr, wi, input logic cj,
                           input int e0r, e0i, e1r, e1i, input string name);
      @(posedge clk); #1;
      set_in(ar, ai, br, bi, wr, wi, cj, 1'b0);
      valid = 1'b1;
      rdy   = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      chk({name, "_lat1"}, vo[k], 1'b0);
      @(posedge clk); #1;
      chk({name, "_lat2"}, vo[k], 1'b1);
      chk(name, act[k], {16'(e1i), 16'(e1r), 16'(e0i), 16'(e0r)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int  n, start_cnt;
      logic take;
      valid = 1'b0;
      rdy   = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      #12;
      for (int k = 0; k < 2; k++) begin
         chk("reset_valid", vo[k], 1'b0);
         chk("reset_last", lo[k], 1'b0);
         chk("reset_data", act[k], 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", ro[1], 1'b1);

      // Directed vectors
      send_lit(1, 8192, 0, 4096, 0, 16384, 0, 1'b0, 6144, 0, 2048, 0, "real_pass");
      send_lit(1, 4096, 0, 0, 0, 0, -16384, 1'b0, 2048, 0, 0, -2048, "minus_j");
      send_lit(1, 4096, 0, 0, 0, 0, -16384, 1'b1, 2048, 0, 0, 2048, "minus_j_inv");
      send_lit(0, 16384, 0, -16384, 0, -16384, 0, 1'b0, 0, 0, 32767, 0, "saturate");
      send_lit(0, 3, 0, 0, 0, 8192, 0, 1'b0, 3, 0, 2, 0, "round_half_up");
      send_lit(0, 2, 0, 0, 0, 0, -32768, 1'b1, 2, 0, 0, 4, "twiddle_neg_sat");
      send_lit(1, -3, 0, 0, 0, 16384, 0, 1'b0, -2, 0, -2, 0, "floor_negative");
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back: 16 samples, o_valid must be continuous from cycle 2
      start_cnt = out_cnt;
      for (int c = 0; c < 18; c++) begin
         valid = (c < 16);
         if (c < 16)
            set_in(20000 - c*2500, c*1999 - 15000, -c*1234, 30000 - c*3700,
                   16384 - c*2048, c*2048 - 16000, c[0], c == 15);
         @(negedge clk);
         if (c >= 2) chk("b2b_continuous", vo[1], 1'b1);
         @(posedge clk); #1;
      end
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_count", 64'(out_cnt - start_cnt), 64'd16);

      // Backpressure: 8 samples, downstream stalls for cycles 3..5
      start_cnt = out_cnt;
      n = 0;
      for (int c = 0; c < 40 && (n < 8 || exp_q.size() != 0); c++) begin
         rdy   = !(c >= 3 && c <= 5);
         valid = (n < 8);
         if (n < 8)
            set_in(n*4000 - 14000, 9000 - n*2600, 12000 - n*3100, n*1500,
                   -16384 + n*4096, 8000 - n*1800, n[1], n == 7);
         @(negedge clk);
         if (!rdy && vo[1]) chk("bp_ready_low", ro[1], 1'b0);
         take = valid && ro[1];
         @(posedge clk); #1;
         if (take) n++;
      end
      valid = 1'b0;
      rdy   = 1'b1;
      chk("bp_accepted", 64'(n), 64'd8);
      chk("bp_outputs", 64'(out_cnt - start_cnt), 64'd8);
      chk("bp_drained", 64'(exp_q.size()), 64'd0);

      // Reset with two samples in flight
      @(posedge clk); #1;
      set_in(1000, 2000, 3000, 4000, 16384, 0, 1'b0, 1'b1);
      valid = 1'b1;
      @(posedge clk); #1;
      set_in(-500, 700, 900, -1100, 8192, 8192, 1'b1, 1'b0);
      @(posedge clk); #1;
      valid = 1'b0;
      rdy   = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("midrst_valid", vo[k], 1'b0);
         chk("midrst_last", lo[k], 1'b0);
         chk("midrst_data", act[k], 64'd0);
      end
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("midrst_ready", ro[1], 1'b1);
      rdy = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("midrst_idle", vo[1], 1'b0);
      end
      send_lit(1, 8192, 0, 4096, 0, 16384, 0, 1'b0, 6144, 0, 2048, 0, "post_reset");

      repeat (3) @(posedge clk);
      #1;
      chk("final_drain", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
